// File: rtl/fuzz_ctl_pkg.sv
// Shared state encoding, polynomial constants and the LFSR step for the fuzz run sequencer.
package fuzz_ctl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS = 32'h00400007;
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] SIG_INIT  = 32'hFFFFFFFF;

    // Galois left-shift step; taps are folded in when the bit shifted out is set.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], 1'b0} ^ (l[31] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/sig_misr.sv
// 32-bit MISR compacting a wide result bus; the bus is XOR-folded into 32-bit slices first.
module sig_misr
    import fuzz_ctl_pkg::*;
#(
    parameter int Y_W = 594
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           en,
    input  logic [Y_W-1:0] data,
    output logic [31:0]    sig
);

    localparam int NSLICE = (Y_W + 31) / 32;

    // Zero-pad at the MSB end so the top slice is complete, then XOR all slices.
    function automatic logic [31:0] fold(input logic [Y_W-1:0] d);
        logic [NSLICE*32-1:0] padded;
        logic [31:0]          acc;
        padded         = '0;
        padded[Y_W-1:0] = d;
        acc            = '0;
        for (int i = 0; i < NSLICE; i++) begin
            acc = acc ^ padded[i*32 +: 32];
        end
        return acc;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : 32'h0) ^ f;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= SIG_INIT;
        end else if (clr) begin
            sig <= SIG_INIT;
        end else if (en) begin
            sig <= misr_step(sig, fold(data));
        end
    end

endmodule

// File: rtl/fuzz_run_sequencer.sv
// Drives LFSR stimulus into a pipelined DUT for run_len cycles and compacts its results into a MISR signature.
module fuzz_run_sequencer
    import fuzz_ctl_pkg::*;
#(
    parameter int STIM_W     = 53,
    parameter int Y_W        = 594,
    parameter int CNT_W      = 16,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       seed,
    input  logic [CNT_W-1:0]  run_len,
    input  logic [Y_W-1:0]    dut_y,
    output logic [STIM_W-1:0] stim,
    output logic              stim_valid,
    output logic              busy,
    output logic              done,
    output logic [31:0]       signature,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int DRAIN_W = (PIPE_DEPTH < 2) ? 1 : $clog2(PIPE_DEPTH + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = 1;
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DEPTH - 1);

    state_t              state_q;
    state_t              state_d;
    logic                start_acc;
    logic [31:0]         seed_q;
    logic [CNT_W-1:0]    run_len_q;
    logic [31:0]         lfsr_q;
    logic [STIM_W-1:0]   stim_hold;
    logic [STIM_W-1:0]   stim_cur;
    logic [63:0]         stim_word;
    logic [CNT_W-1:0]    cycle_cnt_q;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic                last_run;
    logic                drain_last;
    logic [PIPE_DEPTH-1:0] sample_vld_p;
    logic                sample_en;

    assign stim_word  = {lfsr_q, ~lfsr_q};
    assign stim_cur   = stim_word[STIM_W-1:0];
    assign last_run   = (cycle_cnt_q == (run_len_q - CNT_ONE));
    assign drain_last = (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (run_len_q == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (last_run) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q      <= '0;
            run_len_q   <= '0;
            lfsr_q      <= 32'h1;
            stim_hold   <= '0;
            cycle_cnt_q <= '0;
            drain_cnt   <= '0;
        end else begin
            if (start_acc) begin
                seed_q    <= seed;
                run_len_q <= run_len;
            end
            case (state_q)
                ST_LOAD: begin
                    // A zero seed would lock the LFSR at zero forever.
                    lfsr_q      <= (seed_q == '0) ? 32'h1 : seed_q;
                    cycle_cnt_q <= '0;
                    drain_cnt   <= '0;
                end
                ST_RUN: begin
                    stim_hold   <= stim_cur;
                    lfsr_q      <= lfsr_step(lfsr_q);
                    cycle_cnt_q <= (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;
                end
                ST_DRAIN: begin
                    drain_cnt <= drain_cnt + DRAIN_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // stim_valid delayed by the DUT latency marks the cycle its result is on dut_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_vld_p <= '0;
        end else begin
            sample_vld_p[0] <= stim_valid;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                sample_vld_p[i] <= sample_vld_p[i-1];
            end
        end
    end

    assign sample_en = sample_vld_p[PIPE_DEPTH-1];

    sig_misr #(
        .Y_W (Y_W)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == ST_LOAD),
        .en   (sample_en),
        .data (dut_y),
        .sig  (signature)
    );

    assign stim_valid = (state_q == ST_RUN);
    assign stim       = stim_valid ? stim_cur : stim_hold;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_fuzz_run_sequencer.sv
// Randomized bench for fuzz_run_sequencer with a behavioural DUT and a run-level signature model.
module tb_fuzz_run_sequencer;

    localparam int STIM_W = 53;
    localparam int Y_W    = 594;
    localparam int CNT_W  = 16;
    localparam int PD     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       seed;
    logic [CNT_W-1:0]  run_len;
    logic [Y_W-1:0]    dut_y;
    logic [STIM_W-1:0] stim;
    logic              stim_valid;
    logic              busy;
    logic              done;
    logic [31:0]       signature;
    logic [CNT_W-1:0]  cycle_cnt;

    int checks   = 0;
    int failures = 0;

    logic              y_zero;
    logic [31:0]       salt;
    logic [PD-1:0][STIM_W-1:0] dut_pipe;
    logic [STIM_W-1:0] last_first_stim;
    logic [31:0]       last_sig;

    always #5 clk = ~clk;

    fuzz_run_sequencer #(
        .STIM_W(STIM_W), .Y_W(Y_W), .CNT_W(CNT_W), .PIPE_DEPTH(PD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .run_len(run_len),
        .dut_y(dut_y), .stim(stim), .stim_valid(stim_valid), .busy(busy),
        .done(done), .signature(signature), .cycle_cnt(cycle_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural DUT: result is a salted spread of the stimulus, PD cycles later.
    function automatic logic [Y_W-1:0] expand_y(input logic [STIM_W-1:0] s, input logic [31:0] k);
        logic [Y_W-1:0] r;
        for (int i = 0; i < Y_W; i++) r[i] = s[(i * 7) % STIM_W] ^ k[i % 32];
        return r;
    endfunction

    always @(posedge clk) begin
        dut_pipe[0] <= stim;
        for (int i = 1; i < PD; i++) dut_pipe[i] <= dut_pipe[i-1];
    end

    assign dut_y = y_zero ? '0 : expand_y(dut_pipe[PD-1], salt);

    function automatic logic [STIM_W-1:0] stim_of(input logic [31:0] l);
        logic [63:0] w;
        w = {l, ~l};
        return w[STIM_W-1:0];
    endfunction

    // Whole-run reference: every stimulus word of the run folded into the signature.
    function automatic logic [31:0] model_sig(input logic [31:0] sd, input int len,
                                              input logic [31:0] k, input logic zy);
        logic [31:0]    l;
        logic [31:0]    s;
        logic [31:0]    f;
        logic [Y_W-1:0] y;
        l = (sd == 0) ? 32'h1 : sd;
        s = 32'hFFFFFFFF;
        for (int n = 0; n < len; n++) begin
            y = zy ? '0 : expand_y(stim_of(l), k);
            f = '0;
            for (int i = 0; i < Y_W; i++) f[i % 32] = f[i % 32] ^ y[i];
            s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
            l = {l[30:0], 1'b0} ^ (l[31] ? 32'h00400007 : 32'h0);
        end
        return s;
    endfunction

    task automatic run_seq(input string tag, input logic [31:0] sd, input int len, input bit poke);
        int n;
        int nv;
        int exp_n;
        logic [31:0] exp_sig;
        exp_sig = model_sig(sd, len, salt, y_zero);
        exp_n   = (len == 0) ? 2 : 2 + len + PD;
        nv      = 0;
        last_first_stim = '0;
        @(negedge clk);
        seed    = sd;
        run_len = len[CNT_W-1:0];
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        check({tag, ".load_busy"}, 64'(busy), 64'd1);
        check({tag, ".load_done"}, 64'(done), 64'd0);
        check({tag, ".load_vld"}, 64'(stim_valid), 64'd0);
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (stim_valid) begin
                if (nv == 0) last_first_stim = stim;
                nv++;
            end
            if (poke && busy) begin
                start   = 1'($urandom_range(0, 1));
                seed    = $urandom;
                run_len = CNT_W'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(exp_n));
        check({tag, ".nvalid"}, 64'(nv), 64'(len));
        check({tag, ".cnt"}, 64'(cycle_cnt), 64'(len));
        check({tag, ".sig"}, 64'(signature), 64'(exp_sig));
        if (len > 0) check({tag, ".first_stim"}, 64'(last_first_stim), 64'(stim_of((sd == 0) ? 32'h1 : sd)));
        last_sig = signature;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".vld"}, 64'(stim_valid), 64'd0);
        check({tag, ".stim"}, 64'(stim), 64'd0);
        check({tag, ".cnt"}, 64'(cycle_cnt), 64'd0);
        check({tag, ".sig"}, 64'(signature), 64'hFFFFFFFF);
    endtask

    initial begin
        logic [31:0] sd;
        logic [31:0] sig_a;
        logic [31:0] sig_s1;
        rst     = 1'b1;
        start   = 1'b0;
        seed    = '0;
        run_len = '0;
        y_zero  = 1'b1;
        salt    = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Minimal run with zero DUT result: one MISR step from the initial value.
        run_seq("len1", 32'h1, 1, 1'b0);
        check("len1.stim_const", 64'(last_first_stim), 64'h1_FFFF_FFFE);
        check("len1.sig_const", 64'(signature), 64'hFB3EE249);

        // Back-to-back from DONE with a zero length run.
        run_seq("len0", 32'h1234, 0, 1'b0);
        check("len0.sig_const", 64'(signature), 64'hFFFFFFFF);

        y_zero = 1'b0;
        salt   = $urandom;
        sd     = $urandom;
        run_seq("clean", sd, 25, 1'b0);
        sig_a = last_sig;
        run_seq("poked", sd, 25, 1'b1);
        check("poked.same", 64'(last_sig), 64'(sig_a));

        // Reset in the middle of RUN, then rerun the same seed.
        @(negedge clk);
        seed    = sd;
        run_len = 16'd25;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst.sig_quiet", 64'(signature), 64'hFFFFFFFF);
        check("midrst.idle", 64'(busy | done), 64'd0);
        run_seq("rerun", sd, 25, 1'b0);
        check("rerun.same", 64'(last_sig), 64'(sig_a));

        // A zero seed substitutes 1.
        run_seq("seed1", 32'h1, 12, 1'b0);
        sig_s1 = last_sig;
        run_seq("seed0", 32'h0, 12, 1'b0);
        check("seed0.same", 64'(last_sig), 64'(sig_s1));

        for (int r = 0; r < 8; r++) begin
            salt = $urandom;
            run_seq("rand", $urandom, int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
